sc_datapath: RTL and testbench

//  Single-cycle RV32I-subset processor datapath: PC, instruction memory, register file, ALU, data memory, control.
//  Top of the CPU; only clock and reset cross the boundary, and all state is observed hierarchically.

---
 rtl/sc_datapath.sv | 196 +++++++++++++++++++
 tb/tb_sc_datapath.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sc_datapath.sv
// Single-cycle RV32I-subset datapath: PC, instruction memory, register file, ALU, data memory.
// Instruction memory powers up all-zero and is filled hierarchically.

module sc_imem #(
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic [29:0] word_idx_i,
  output logic [31:0] instr_o
);
  localparam int unsigned Aw = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [31:0] instr_memory [IMEM_DEPTH] = '{default: '0};

  // Combinational fetch; past the end of memory reads as a NOP.
  always_comb begin
    instr_o = '0;
    if ({2'b00, word_idx_i} < IMEM_DEPTH) instr_o = instr_memory[word_idx_i[Aw-1:0]];
  end
endmodule

module sc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] reg_file [32];

  // Synchronous clear on reset; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) reg_file[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      reg_file[waddr_i] <= wdata_i;
    end
  end

  // Combinational reads; x0 is hard-wired to zero.
  always_comb begin
    rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : reg_file[raddr1_i];
    rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : reg_file[raddr2_i];
  end
endmodule

module sc_dmem #(
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [29:0] word_idx_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  localparam int unsigned Aw = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [31:0] data_memory [DMEM_DEPTH];
  logic        in_range;

  assign in_range = ({2'b00, word_idx_i} < DMEM_DEPTH);

  // Contents are not cleared by reset, but no store may land in a reset cycle.
  always_ff @(posedge clk) begin
    if (rst && we_i && in_range) data_memory[word_idx_i[Aw-1:0]] <= wdata_i;
  end

  // Combinational load; out-of-range reads return zero.
  always_comb begin
    rdata_o = in_range ? data_memory[word_idx_i[Aw-1:0]] : 32'd0;
  end
endmodule

module sc_datapath #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input logic clk,
  input logic rst
);
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr, rs1_val, rs2_val, rf_wdata, dm_addr, dm_rdata;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        rf_we, dm_we;
  logic        unused_addr_lsbs;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;
  // Kept outside the decode block so the load path has no false combinational loop.
  assign dm_addr  = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
  assign unused_addr_lsbs = ^dm_addr[1:0];

  sc_imem #(.IMEM_DEPTH(IMEM_DEPTH)) im1 (
    .word_idx_i(pc_q[31:2]),
    .instr_o   (instr)
  );

  sc_regfile rf1 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (rf_we),
    .waddr_i (instr[11:7]),
    .wdata_i (rf_wdata),
    .raddr1_i(instr[19:15]),
    .raddr2_i(instr[24:20]),
    .rdata1_o(rs1_val),
    .rdata2_o(rs2_val)
  );

  sc_dmem #(.DMEM_DEPTH(DMEM_DEPTH)) dm1 (
    .clk       (clk),
    .rst       (rst),
    .we_i      (dm_we),
    .word_idx_i(dm_addr[31:2]),
    .wdata_i   (rs2_val),
    .rdata_o   (dm_rdata)
  );

  // Decode and execute; anything not recognised falls through as a NOP.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    dm_we    = 1'b0;
    pc_d     = pc_plus4;
    case (opcode)
      OpR: begin
        rf_we = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: rf_wdata = rs1_val + rs2_val;
          {7'h20, 3'b000}: rf_wdata = rs1_val - rs2_val;
          {7'h00, 3'b111}: rf_wdata = rs1_val & rs2_val;
          {7'h00, 3'b110}: rf_wdata = rs1_val | rs2_val;
          {7'h00, 3'b100}: rf_wdata = rs1_val ^ rs2_val;
          {7'h00, 3'b010}: rf_wdata = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
          {7'h00, 3'b011}: rf_wdata = {31'd0, rs1_val < rs2_val};
          default:         rf_we    = 1'b0;
        endcase
      end
      OpImm: begin
        rf_we = 1'b1;
        case (funct3)
          3'b000:  rf_wdata = rs1_val + imm_i;
          3'b111:  rf_wdata = rs1_val & imm_i;
          3'b110:  rf_wdata = rs1_val | imm_i;
          3'b010:  rf_wdata = {31'd0, $signed(rs1_val) < $signed(imm_i)};
          default: rf_we    = 1'b0;
        endcase
      end
      OpLoad: begin
        if (funct3 == 3'b010) begin
          rf_we    = 1'b1;
          rf_wdata = dm_rdata;
        end
      end
      OpStore: dm_we = (funct3 == 3'b010);
      OpBranch: begin
        if (((funct3 == 3'b000) && (rs1_val == rs2_val)) ||
            ((funct3 == 3'b001) && (rs1_val != rs2_val))) begin
          pc_d = pc_q + imm_b;
        end
      end
      OpJal: begin
        rf_we    = 1'b1;
        rf_wdata = pc_plus4;
        pc_d     = pc_q + imm_j;
      end
      default: ;
    endcase
  end

  // Program counter with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end
endmodule

// File: tb/tb_sc_datapath.sv
// Directed bench for sc_datapath: programs are poked into im1.instr_memory, state is peeked.
module tb_sc_datapath;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [31:0] prog [$];

  sc_datapath dut (
    .clk(clk),
    .rst(rst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Hold reset, replace the program, then release reset just after an edge.
  task automatic load_and_reset();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) dut.im1.instr_memory[i] = 32'd0;
    foreach (prog[i]) dut.im1.instr_memory[i] = prog[i];
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    prog = {};
    load_and_reset();
    n_vec++; if (dut.pc_q !== 32'd0) begin n_miss++; $display("FAIL reset_pc got %h want %h", dut.pc_q, 32'd0); end
    n_vec++; if (dut.rf1.reg_file[1] !== 32'd0) begin n_miss++; $display("FAIL reset_x1 got %h want 0", dut.rf1.reg_file[1]); end
    n_vec++; if (dut.rf1.reg_file[31] !== 32'd0) begin n_miss++; $display("FAIL reset_x31 got %h want 0", dut.rf1.reg_file[31]); end
    step(3);
    n_vec++; if (dut.pc_q !== 32'd12) begin n_miss++; $display("FAIL nop_pc got %h want %h", dut.pc_q, 32'd12); end
  endtask

  task automatic test_lw();
    prog = {addi(5, 0, 5),  enc_s(0, 5, 0),  addi(5, 0, 10), enc_s(4, 5, 0),
            addi(5, 0, 20), enc_s(8, 5, 0),  addi(5, 0, 30), enc_s(12, 5, 0),
            addi(5, 0, 40), enc_s(16, 5, 0)};
    load_and_reset();
    step(10);
    n_vec++; if (dut.dm1.data_memory[0] !== 32'd5) begin n_miss++; $display("FAIL preload_m0 got %h want 5", dut.dm1.data_memory[0]); end
    n_vec++; if (dut.dm1.data_memory[4] !== 32'd40) begin n_miss++; $display("FAIL preload_m4 got %h want 28", dut.dm1.data_memory[4]); end
    prog = {32'h0000_2083};  // lw x1,0(x0)
    load_and_reset();
    n_vec++; if (dut.rf1.reg_file[5] !== 32'd0) begin n_miss++; $display("FAIL reset_clears_x5 got %h want 0", dut.rf1.reg_file[5]); end
    n_vec++; if (dut.dm1.data_memory[1] !== 32'd10) begin n_miss++; $display("FAIL mem_survives_reset got %h want a", dut.dm1.data_memory[1]); end
    step(1);
    n_vec++; if (dut.rf1.reg_file[1] !== 32'd5) begin n_miss++; $display("FAIL lw_x1 got %h want 5", dut.rf1.reg_file[1]); end
    n_vec++; if (dut.pc_q !== 32'd4) begin n_miss++; $display("FAIL lw_pc got %h want 4", dut.pc_q); end
  endtask

  task automatic test_add_sw();
    prog = {32'h0000_2083, enc_i(4, 0, 3'b010, 2, 7'b0000011), 32'h0020_80B3, enc_s(8, 1, 0)};
    load_and_reset();
    step(4);
    n_vec++; if (dut.rf1.reg_file[1] !== 32'h0000_000F) begin n_miss++; $display("FAIL add_x1 got %h want f", dut.rf1.reg_file[1]); end
    n_vec++; if (dut.rf1.reg_file[2] !== 32'd10) begin n_miss++; $display("FAIL lw_x2 got %h want a", dut.rf1.reg_file[2]); end
    n_vec++; if (dut.dm1.data_memory[2] !== 32'h0000_000F) begin n_miss++; $display("FAIL sw_m2 got %h want f", dut.dm1.data_memory[2]); end
    n_vec++; if (dut.dm1.data_memory[3] !== 32'd30) begin n_miss++; $display("FAIL m3_untouched got %h want 1e", dut.dm1.data_memory[3]); end
  endtask

  task automatic test_x0();
    prog = {addi(1, 0, 9), addi(0, 0, 7), enc_r(7'h00, 0, 0, 3'b000, 1)};
    load_and_reset();
    step(1);
    n_vec++; if (dut.rf1.reg_file[1] !== 32'd9) begin n_miss++; $display("FAIL addi_x1 got %h want 9", dut.rf1.reg_file[1]); end
    step(2);
    n_vec++; if (dut.rf1.reg_file[1] !== 32'd0) begin n_miss++; $display("FAIL x0_reads_zero got %h want 0", dut.rf1.reg_file[1]); end
  endtask

  task automatic test_branch();
    prog = {addi(1, 0, 3), addi(2, 0, 3), enc_b(8, 2, 1, 3'b000), addi(3, 0, 1),
            enc_b(8, 2, 1, 3'b001), addi(4, 0, 2)};
    load_and_reset();
    step(3);
    n_vec++; if (dut.pc_q !== 32'd16) begin n_miss++; $display("FAIL beq_taken_pc got %h want 10", dut.pc_q); end
    step(1);
    n_vec++; if (dut.pc_q !== 32'd20) begin n_miss++; $display("FAIL bne_not_taken_pc got %h want 14", dut.pc_q); end
    step(1);
    n_vec++; if (dut.rf1.reg_file[4] !== 32'd2) begin n_miss++; $display("FAIL fallthrough_x4 got %h want 2", dut.rf1.reg_file[4]); end
    n_vec++; if (dut.rf1.reg_file[3] !== 32'd0) begin n_miss++; $display("FAIL skipped_x3 got %h want 0", dut.rf1.reg_file[3]); end
  endtask

  task automatic test_jal_slt();
    prog = {enc_j(12, 1), 32'd0, 32'd0, addi(5, 0, 1), enc_r(7'h20, 5, 0, 3'b000, 1),
            enc_r(7'h00, 1, 0, 3'b011, 3), enc_r(7'h00, 1, 0, 3'b010, 4),
            enc_i(0, 1, 3'b010, 6, 7'b0010011), enc_j(32'hFFFF_FFE0, 0)};
    load_and_reset();
    step(1);
    n_vec++; if (dut.pc_q !== 32'd12) begin n_miss++; $display("FAIL jal_pc got %h want c", dut.pc_q); end
    n_vec++; if (dut.rf1.reg_file[1] !== 32'd4) begin n_miss++; $display("FAIL jal_link got %h want 4", dut.rf1.reg_file[1]); end
    step(3);
    n_vec++; if (dut.rf1.reg_file[1] !== 32'hFFFF_FFFF) begin n_miss++; $display("FAIL sub_neg got %h want ffffffff", dut.rf1.reg_file[1]); end
    n_vec++; if (dut.rf1.reg_file[3] !== 32'd1) begin n_miss++; $display("FAIL sltu got %h want 1", dut.rf1.reg_file[3]); end
    step(2);
    n_vec++; if (dut.rf1.reg_file[4] !== 32'd0) begin n_miss++; $display("FAIL slt_signed got %h want 0", dut.rf1.reg_file[4]); end
    n_vec++; if (dut.rf1.reg_file[6] !== 32'd1) begin n_miss++; $display("FAIL slti got %h want 1", dut.rf1.reg_file[6]); end
    step(1);
    n_vec++; if (dut.pc_q !== 32'd0) begin n_miss++; $display("FAIL jal_back_pc got %h want 0", dut.pc_q); end
  endtask

  task automatic test_logic();
    prog = {addi(1, 0, 32'h0F0), addi(2, 0, 32'hFFFF_FF00), enc_r(7'h00, 2, 1, 3'b111, 3),
            enc_r(7'h00, 2, 1, 3'b110, 4), enc_r(7'h00, 2, 1, 3'b100, 5),
            enc_i(32'h7F0, 2, 3'b111, 6, 7'b0010011), enc_i(32'h00F, 1, 3'b110, 7, 7'b0010011),
            addi(8, 2, 256), addi(9, 0, 5), enc_i(1024, 0, 3'b010, 9, 7'b0000011),
            32'hFFFF_FFFF, addi(10, 0, 1)};
    load_and_reset();
    step(9);
    n_vec++; if (dut.rf1.reg_file[3] !== 32'd0) begin n_miss++; $display("FAIL and got %h want 0", dut.rf1.reg_file[3]); end
    n_vec++; if (dut.rf1.reg_file[4] !== 32'hFFFF_FFF0) begin n_miss++; $display("FAIL or got %h want fffffff0", dut.rf1.reg_file[4]); end
    n_vec++; if (dut.rf1.reg_file[5] !== 32'hFFFF_FFF0) begin n_miss++; $display("FAIL xor got %h want fffffff0", dut.rf1.reg_file[5]); end
    n_vec++; if (dut.rf1.reg_file[6] !== 32'h0000_0700) begin n_miss++; $display("FAIL andi got %h want 700", dut.rf1.reg_file[6]); end
    n_vec++; if (dut.rf1.reg_file[7] !== 32'h0000_00FF) begin n_miss++; $display("FAIL ori got %h want ff", dut.rf1.reg_file[7]); end
    n_vec++; if (dut.rf1.reg_file[8] !== 32'd0) begin n_miss++; $display("FAIL addi_wrap got %h want 0", dut.rf1.reg_file[8]); end
    n_vec++; if (dut.rf1.reg_file[9] !== 32'd5) begin n_miss++; $display("FAIL addi_x9 got %h want 5", dut.rf1.reg_file[9]); end
    step(3);
    n_vec++; if (dut.rf1.reg_file[9] !== 32'd0) begin n_miss++; $display("FAIL lw_out_of_range got %h want 0", dut.rf1.reg_file[9]); end
    n_vec++; if (dut.rf1.reg_file[10] !== 32'd1) begin n_miss++; $display("FAIL after_bad_op got %h want 1", dut.rf1.reg_file[10]); end
    n_vec++; if (dut.pc_q !== 32'd48) begin n_miss++; $display("FAIL bad_op_pc got %h want 30", dut.pc_q); end
  endtask

  task automatic test_reset_mid();
    prog = {addi(1, 0, 1), enc_s(40, 1, 0), addi(1, 0, 2), enc_s(40, 1, 0)};
    load_and_reset();
    step(3);
    n_vec++; if (dut.dm1.data_memory[10] !== 32'd1) begin n_miss++; $display("FAIL pre_reset_m10 got %h want 1", dut.dm1.data_memory[10]); end
    n_vec++; if (dut.pc_q !== 32'd12) begin n_miss++; $display("FAIL pre_reset_pc got %h want c", dut.pc_q); end
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    n_vec++; if (dut.pc_q !== 32'd0) begin n_miss++; $display("FAIL mid_reset_pc got %h want 0", dut.pc_q); end
    n_vec++; if (dut.rf1.reg_file[1] !== 32'd0) begin n_miss++; $display("FAIL mid_reset_x1 got %h want 0", dut.rf1.reg_file[1]); end
    n_vec++; if (dut.dm1.data_memory[10] !== 32'd1) begin n_miss++; $display("FAIL no_sw_in_reset got %h want 1", dut.dm1.data_memory[10]); end
    step(4);
    n_vec++; if (dut.dm1.data_memory[10] !== 32'd2) begin n_miss++; $display("FAIL rerun_m10 got %h want 2", dut.dm1.data_memory[10]); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_add_sw();
    test_x0();
    test_branch();
    test_jal_slt();
    test_logic();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
